// File: rtl/rram_pulse_sequencer.sv
// rram_pulse_sequencer: drives one RRAM row through clear, set-pulse programming,
// read window and an optional back-propagation pulse.
// Optional feature macro: RRAM_BACKPROP_EN enables the BACK phase and back_req.
// All outputs are registered and take the value of the state being entered.
module rram_pulse_sequencer #(
   parameter int N_COL    = 4,
   parameter int W_BITS   = 4,
   parameter int UNIT_CYC = 10,
   parameter int CLR_CYC  = 4,
   parameter int READ_CYC = 8,
   parameter int BACK_CYC = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [N_COL*W_BITS-1:0]   weight,
   input  logic                      back_req,
   output logic                      busy,
   output logic                      done,
   output logic                      wl,
   output logic [2*N_COL-1:0]        bl_lvl,
   output logic                      dback,
   output logic [2:0]                phase
);

   localparam int PW     = W_BITS + $clog2(UNIT_CYC + 1);
   localparam int PH_MAX = (CLR_CYC > READ_CYC) ?
                           ((CLR_CYC > BACK_CYC) ? CLR_CYC : BACK_CYC) :
                           ((READ_CYC > BACK_CYC) ? READ_CYC : BACK_CYC);
   localparam int PH_W   = $clog2(PH_MAX + 1);
   localparam int CW     = (PW > PH_W) ? PW : PH_W;

   localparam logic [PW-1:0] UNIT_P    = PW'(UNIT_CYC);
   localparam logic [CW-1:0] CLR_LAST  = CW'(CLR_CYC - 1);
   localparam logic [CW-1:0] READ_LAST = CW'(READ_CYC - 1);
   localparam logic [CW-1:0] BACK_LAST = CW'(BACK_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLR   = 3'd1,
      S_SETUP = 3'd2,
      S_SET   = 3'd3,
      S_READ  = 3'd4,
      S_BACK  = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   state_t                    state;
   state_t                    nxt;
   logic [CW-1:0]             cnt;
   logic [CW-1:0]             cnt_nxt;
   logic [N_COL*W_BITS-1:0]   weight_l;
   logic [PW-1:0]             pulse_len [N_COL];
   logic [PW-1:0]             max_len;
   logic                      back_go;
   logic                      wl_nxt;
   logic [2*N_COL-1:0]        bl_nxt;
   logic                      dback_nxt;
   logic                      busy_nxt;
   logic                      done_nxt;

`ifdef RRAM_BACKPROP_EN
   logic back_l;

   // Capture the back-propagation request together with the weights.
   always_ff @(posedge clk) begin
      if (rst) begin
         back_l <= 1'b0;
      end else if (state == S_IDLE && start) begin
         back_l <= back_req;
      end
   end

   assign back_go = back_l;
`else
   logic unused_back_req;
   assign unused_back_req = back_req;
   assign back_go         = 1'b0;
`endif

   // Per-column SET pulse length and the longest of them (sets SET duration).
   always_comb begin
      pulse_len = '{default: '0};
      max_len   = '0;
      for (int i = 0; i < N_COL; i++) begin
         pulse_len[i] = PW'(weight_l[i*W_BITS +: W_BITS]) * UNIT_P;
         if (pulse_len[i] > max_len) begin
            max_len = pulse_len[i];
         end else begin
            max_len = max_len;
         end
      end
   end

   // Next state, phase counter and the output levels of the state being entered.
   always_comb begin
      nxt       = state;
      cnt_nxt   = cnt;
      wl_nxt    = wl;
      bl_nxt    = '0;
      dback_nxt = 1'b0;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;

      case (state)
         S_IDLE: begin
            cnt_nxt = '0;
            if (start) begin
               nxt = S_CLR;
            end else begin
               nxt = S_IDLE;
            end
         end
         S_CLR: begin
            if (cnt == CLR_LAST) begin
               nxt     = S_SETUP;
               cnt_nxt = '0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         S_SETUP: begin
            cnt_nxt = '0;
            if (max_len == '0) begin
               nxt = S_READ;
            end else begin
               nxt = S_SET;
            end
         end
         S_SET: begin
            if ((cnt + CW'(1)) == CW'(max_len)) begin
               nxt     = S_READ;
               cnt_nxt = '0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         S_READ: begin
            if (cnt == READ_LAST) begin
               cnt_nxt = '0;
               if (back_go) begin
                  nxt = S_BACK;
               end else begin
                  nxt = S_DONE;
               end
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         S_BACK: begin
            if (cnt == BACK_LAST) begin
               nxt     = S_DONE;
               cnt_nxt = '0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         S_DONE: begin
            nxt     = S_IDLE;
            cnt_nxt = '0;
         end
         default: begin
            nxt     = S_IDLE;
            cnt_nxt = '0;
         end
      endcase

      case (nxt)
         S_IDLE: begin
            wl_nxt = wl;
         end
         S_CLR: begin
            wl_nxt   = 1'b0;
            busy_nxt = 1'b1;
         end
         S_SETUP: begin
            wl_nxt   = 1'b1;
            busy_nxt = 1'b1;
         end
         S_SET: begin
            wl_nxt   = 1'b1;
            busy_nxt = 1'b1;
            for (int i = 0; i < N_COL; i++) begin
               bl_nxt[2*i +: 2] = (cnt_nxt < CW'(pulse_len[i])) ? 2'b10 : 2'b00;
            end
         end
         S_READ: begin
            wl_nxt   = 1'b1;
            busy_nxt = 1'b1;
         end
         S_BACK: begin
            wl_nxt   = 1'b1;
            busy_nxt = 1'b1;
`ifdef RRAM_BACKPROP_EN
            dback_nxt = 1'b1;
            bl_nxt    = {N_COL{2'b01}};
`else
            dback_nxt = 1'b0;
            bl_nxt    = '0;
`endif
         end
         S_DONE: begin
            wl_nxt   = 1'b1;
            done_nxt = 1'b1;
         end
         default: begin
            wl_nxt = 1'b0;
         end
      endcase
   end

   // State, counter, latched weights and registered row levels.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         weight_l <= '0;
         wl       <= 1'b0;
         bl_lvl   <= '0;
         dback    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state  <= nxt;
         cnt    <= cnt_nxt;
         wl     <= wl_nxt;
         bl_lvl <= bl_nxt;
         dback  <= dback_nxt;
         busy   <= busy_nxt;
         done   <= done_nxt;
         if (state == S_IDLE && start) begin
            weight_l <= weight;
         end
      end
   end

   assign phase = state;

endmodule

// File: tb/tb_rram_pulse_sequencer.sv
// Bench for rram_pulse_sequencer: table of programming sequences with a per-cycle
// expected trace queue, plus hand sequences for reset and start corner cases.
module tb_rram_pulse_sequencer;

   localparam int UNIT = 10;
   localparam int CLRC = 4;
   localparam int RDC  = 8;
   localparam int BKC  = 5;
`ifdef RRAM_BACKPROP_EN
   localparam bit BACKEN = 1'b1;
`else
   localparam bit BACKEN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] weight;
   logic        back_req;
   logic        busy, done, wl, dback;
   logic [7:0]  bl_lvl;
   logic [2:0]  phase;

   int n_checks = 0;
   int n_fail   = 0;

   rram_pulse_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .weight(weight), .back_req(back_req),
      .busy(busy), .done(done), .wl(wl), .bl_lvl(bl_lvl), .dback(dback), .phase(phase)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       wl;
      logic [7:0] bl;
      logic       dback;
      logic       busy;
      logic       done;
      logic [2:0] phase;
   } rec_t;

   typedef struct {
      logic [15:0] w;
      logic        back;
      int          done_cyc;
      int          pw0, pw1, pw2, pw3;
      int          dback_cyc;
      int          glitch;
      bit          start_at_done;
   } vec_t;

   rec_t exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic rec_t mk(input logic w, input logic [7:0] b, input logic d,
                               input logic bz, input logic dn, input logic [2:0] ph);
      rec_t r;
      r.wl = w; r.bl = b; r.dback = d; r.busy = bz; r.done = dn; r.phase = ph;
      return r;
   endfunction

   // Expected output of every cycle after the accept edge, from the phase durations.
   task automatic push_trace(input logic [15:0] w, input logic back);
      int wi[4];
      int mx;
      logic [7:0] b;
      mx = 0;
      for (int i = 0; i < 4; i++) begin
         wi[i] = int'(w[4*i +: 4]);
         if (wi[i] > mx) mx = wi[i];
      end
      for (int k = 0; k < CLRC; k++) exp_q.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd1));
      exp_q.push_back(mk(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 3'd2));
      for (int k = 0; k < mx * UNIT; k++) begin
         b = 8'h00;
         for (int i = 0; i < 4; i++) if (k < wi[i] * UNIT) b[2*i +: 2] = 2'b10;
         exp_q.push_back(mk(1'b1, b, 1'b0, 1'b1, 1'b0, 3'd3));
      end
      for (int k = 0; k < RDC; k++) exp_q.push_back(mk(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 3'd4));
      if (BACKEN && back)
         for (int k = 0; k < BKC; k++) exp_q.push_back(mk(1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 3'd5));
      exp_q.push_back(mk(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 3'd6));
      exp_q.push_back(mk(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0));
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      rec_t got, exp;
      int   c, done_at, dback_n, n_done;
      int   wc[4];
      done_at = -1; dback_n = 0; n_done = 0;
      for (int i = 0; i < 4; i++) wc[i] = 0;
      @(negedge clk);
      weight = v.w; back_req = v.back; start = 1'b1;
      push_trace(v.w, v.back);
      c = 0;
      while (exp_q.size() > 0 && c < 400) begin
         @(posedge clk); #1;
         c++;
         got = {wl, bl_lvl, dback, busy, done, phase};
         exp = exp_q.pop_front();
         check($sformatf("v%0d trace cyc %0d", idx, c), 32'(got), 32'(exp));
         for (int i = 0; i < 4; i++) if (bl_lvl[2*i +: 2] == 2'b10) wc[i]++;
         if (dback) dback_n++;
         if (done) begin
            n_done++;
            if (done_at < 0) done_at = c;
         end
         start = 1'b0;
         if (c == v.glitch) begin
            weight = 16'hFFFF; start = 1'b1;
         end
         if (v.start_at_done && done) start = 1'b1;
      end
      check($sformatf("v%0d trace drained", idx), 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      start = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (done) n_done++;
         if (busy) n_done += 100;
      end
      check($sformatf("v%0d done cycle", idx), 32'(done_at), 32'(v.done_cyc));
      check($sformatf("v%0d single done, no restart", idx), 32'(n_done), 32'd1);
      check($sformatf("v%0d col0 width", idx), 32'(wc[0]), 32'(v.pw0));
      check($sformatf("v%0d col1 width", idx), 32'(wc[1]), 32'(v.pw1));
      check($sformatf("v%0d col2 width", idx), 32'(wc[2]), 32'(v.pw2));
      check($sformatf("v%0d col3 width", idx), 32'(wc[3]), 32'(v.pw3));
      check($sformatf("v%0d dback cycles", idx), 32'(dback_n), 32'(v.dback_cyc));
   endtask

   vec_t vecs[5];

   initial begin
      int set_seen;
      vecs[0] = '{16'h3012, 1'b0, 44, 20, 10, 0, 30, 0, 0, 1'b0};
      vecs[1] = '{16'h0000, 1'b0, 14, 0, 0, 0, 0, 0, 0, 1'b0};
      vecs[2] = '{16'hF001, 1'b0, 164, 10, 0, 0, 150, 0, 0, 1'b0};
`ifdef RRAM_BACKPROP_EN
      vecs[3] = '{16'h1111, 1'b1, 29, 10, 10, 10, 10, 5, 0, 1'b0};
`else
      vecs[3] = '{16'h1111, 1'b1, 24, 10, 10, 10, 10, 0, 0, 1'b0};
`endif
      vecs[4] = '{16'h0002, 1'b0, 34, 20, 0, 0, 0, 0, 10, 1'b1};

      rst = 1'b1; start = 1'b0; weight = 16'h0000; back_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset state", 32'({wl, bl_lvl, dback, busy, done, phase}), 32'd0);
      @(negedge clk); rst = 1'b0;

      for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

      // Reset held for two cycles in the middle of SET aborts the sequence.
      @(negedge clk);
      weight = 16'h3012; back_req = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("mid-SET phase before reset", 32'(phase), 32'd3);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      check("reset edge 1 outputs", 32'({wl, bl_lvl, dback, busy, done, phase}), 32'd0);
      @(posedge clk); #1;
      check("reset edge 2 outputs", 32'({wl, bl_lvl, dback, busy, done, phase}), 32'd0);
      @(negedge clk); rst = 1'b0;
      set_seen = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (busy || done || wl || phase != 3'd0) set_seen++;
      end
      check("idle after reset release", 32'(set_seen), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
